// File: rtl/status_trap_ctrl_if.sv
// rtl/status_trap_ctrl_if.sv - request/ready handshakes between the pipeline and the status/trap sequencer
//
// Groups the three requester handshakes (CSR write, exception, eret) and the
// pipeline drain handshake.
//   master : pipeline side (drives requests and drain_done, receives readies and drain_req)
//   slave  : status_trap_ctrl side
interface status_trap_ctrl_if;
    logic        io_csr_wen;
    logic [31:0] io_csr_wdata;
    logic        io_csr_ready;
    logic        io_exc_valid;
    logic [4:0]  io_exc_cause;
    logic        io_exc_ready;
    logic        io_eret_valid;
    logic        io_eret_ready;
    logic        io_drain_req;
    logic        io_drain_done;

    modport master (
        output io_csr_wen, io_csr_wdata, io_exc_valid, io_exc_cause,
               io_eret_valid, io_drain_done,
        input  io_csr_ready, io_exc_ready, io_eret_ready, io_drain_req
    );

    modport slave (
        input  io_csr_wen, io_csr_wdata, io_exc_valid, io_exc_cause,
               io_eret_valid, io_drain_done,
        output io_csr_ready, io_exc_ready, io_eret_ready, io_drain_req
    );
endinterface

// File: rtl/status_trap_ctrl.sv
// rtl/status_trap_ctrl.sv - processor status register owner and trap sequencer
//
// Owns the packed status word and arbitrates exception > interrupt > eret >
// CSR write, one action per cycle while in RUN. Traps are committed only after
// the pipeline acknowledges a drain request.
//   clk, reset_n      : clock, asynchronous active-low reset
//   bus (slave)       : CSR / exception / eret handshakes and drain handshake
//   io_ip             : interrupt pending lines
//   io_trap_fire      : one-cycle pulse when a trap commits
//   io_trap_cause     : latched cause, bit5 = interrupt, [4:0] = code
//   io_status_*       : individual status fields
//   io_status_bits    : packed readback of the status word
module status_trap_ctrl (
    input  logic                 clk,
    input  logic                 reset_n,
    status_trap_ctrl_if.slave    bus,
    input  logic [7:0]           io_ip,
    output logic                 io_trap_fire,
    output logic [5:0]           io_trap_cause,
    output logic                 io_status_et,
    output logic                 io_status_ef,
    output logic                 io_status_ev,
    output logic                 io_status_ec,
    output logic                 io_status_ps,
    output logic                 io_status_s,
    output logic                 io_status_u64,
    output logic                 io_status_s64,
    output logic                 io_status_vm,
    output logic [6:0]           io_status_zero,
    output logic [7:0]           io_status_im,
    output logic [31:0]          io_status_bits
);

    // Bit positions inside the packed status word.
    localparam int ET  = 0;
    localparam int EF  = 1;
    localparam int EV  = 2;
    localparam int EC  = 3;
    localparam int PS  = 4;
    localparam int S   = 5;
    localparam int U64 = 6;
    localparam int S64 = 7;
    localparam int VM  = 8;

    // Writable bits: fields [8:0] and im [23:16]; zero [15:9] and [31:24] stay 0.
    localparam logic [31:0] WRITE_MASK   = 32'h00FF_01FF;
    localparam logic [31:0] RESET_STATUS = 32'h0000_0020;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_TRAP  = 2'd2
    } state_t;

    state_t      state_q,  state_d;
    logic [31:0] status_q, status_d;
    logic [5:0]  cause_q,  cause_d;

    logic [7:0]  irq_hits;
    logic        irq_pend;
    logic [2:0]  irq_idx;

    assign irq_hits = status_q[23:16] & io_ip;
    assign irq_pend = status_q[ET] & (|irq_hits);

    // Lowest-numbered enabled pending line wins: scan high to low so the last
    // match (the lowest index) is what remains.
    always_comb begin
        irq_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (irq_hits[i]) begin
                irq_idx = i[2:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_RUN;
            status_q <= RESET_STATUS;
            cause_q  <= 6'd0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            cause_q  <= cause_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        status_d          = status_q;
        cause_d           = cause_q;
        bus.io_csr_ready  = 1'b0;
        bus.io_exc_ready  = 1'b0;
        bus.io_eret_ready = 1'b0;
        bus.io_drain_req  = 1'b0;
        io_trap_fire      = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (bus.io_exc_valid) begin
                    bus.io_exc_ready = 1'b1;
                    cause_d          = {1'b0, bus.io_exc_cause};
                    state_d          = ST_DRAIN;
                end else if (irq_pend) begin
                    // Interrupts have no ready; the cause is captured here and
                    // held through DRAIN regardless of later io_ip changes.
                    cause_d = {1'b1, 2'b00, irq_idx};
                    state_d = ST_DRAIN;
                end else if (bus.io_eret_valid) begin
                    bus.io_eret_ready = 1'b1;
                    status_d[S]       = status_q[PS];
                    status_d[ET]      = 1'b1;
                end else if (bus.io_csr_wen) begin
                    bus.io_csr_ready = 1'b1;
                    status_d         = bus.io_csr_wdata & WRITE_MASK;
                end
            end

            ST_DRAIN: begin
                bus.io_drain_req = 1'b1;
                if (bus.io_drain_done) begin
                    state_d = ST_TRAP;
                end
            end

            ST_TRAP: begin
                io_trap_fire = 1'b1;
                status_d[PS] = status_q[S];
                status_d[S]  = 1'b1;
                status_d[ET] = 1'b0;
                state_d      = ST_RUN;
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign io_trap_cause  = cause_q;
    assign io_status_et   = status_q[ET];
    assign io_status_ef   = status_q[EF];
    assign io_status_ev   = status_q[EV];
    assign io_status_ec   = status_q[EC];
    assign io_status_ps   = status_q[PS];
    assign io_status_s    = status_q[S];
    assign io_status_u64  = status_q[U64];
    assign io_status_s64  = status_q[S64];
    assign io_status_vm   = status_q[VM];
    assign io_status_zero = status_q[15:9];
    assign io_status_im   = status_q[23:16];
    assign io_status_bits = status_q;

endmodule

// File: tb/tb_status_trap_ctrl.sv
// tb/tb_status_trap_ctrl.sv - directed vector bench for status_trap_ctrl
module tb_status_trap_ctrl;

    logic        clk;
    logic        reset_n;
    logic [7:0]  ip;
    logic        trap_fire;
    logic [5:0]  trap_cause;
    logic        st_et, st_ef, st_ev, st_ec, st_ps, st_s, st_u64, st_s64, st_vm;
    logic [6:0]  st_zero;
    logic [7:0]  st_im;
    logic [31:0] st_bits;

    int total;
    int bad;

    status_trap_ctrl_if bus ();

    status_trap_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .bus            (bus.slave),
        .io_ip          (ip),
        .io_trap_fire   (trap_fire),
        .io_trap_cause  (trap_cause),
        .io_status_et   (st_et),
        .io_status_ef   (st_ef),
        .io_status_ev   (st_ev),
        .io_status_ec   (st_ec),
        .io_status_ps   (st_ps),
        .io_status_s    (st_s),
        .io_status_u64  (st_u64),
        .io_status_s64  (st_s64),
        .io_status_vm   (st_vm),
        .io_status_zero (st_zero),
        .io_status_im   (st_im),
        .io_status_bits (st_bits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        csr_wen;
        logic [31:0] wdata;
        logic        exc_valid;
        logic [4:0]  exc_cause;
        logic        eret_valid;
        logic [7:0]  ip;
        logic        drain_done;
        logic        csr_ready;
        logic        exc_ready;
        logic        eret_ready;
        logic        drain_req;
        logic        trap_fire;
        logic [5:0]  cause;
        logic [31:0] bits;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic cw, input logic [31:0] wd, input logic ev,
                                input logic [4:0] ec, input logic er, input logic [7:0] p,
                                input logic dd, input logic xcr, input logic xer,
                                input logic xrr, input logic xdq, input logic xtf,
                                input logic [5:0] xc, input logic [31:0] xb);
        vec_t v;
        v.csr_wen = cw;  v.wdata = wd;  v.exc_valid = ev;  v.exc_cause = ec;
        v.eret_valid = er;  v.ip = p;  v.drain_done = dd;
        v.csr_ready = xcr;  v.exc_ready = xer;  v.eret_ready = xrr;
        v.drain_req = xdq;  v.trap_fire = xtf;  v.cause = xc;  v.bits = xb;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.io_csr_wen    = v.csr_wen;
        bus.io_csr_wdata  = v.wdata;
        bus.io_exc_valid  = v.exc_valid;
        bus.io_exc_cause  = v.exc_cause;
        bus.io_eret_valid = v.eret_valid;
        ip                = v.ip;
        bus.io_drain_done = v.drain_done;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] fields;

    initial begin
        total = 0;
        bad   = 0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        reset_n = 1'b0;

        //            csr wdata         exc cause eret ip    dd | cr er rr dq tf cause  bits
        vecs[0]  = mk(0, 32'h0,         0, 5'h00, 0, 8'h00, 0, 0, 0, 0, 0, 0, 6'h00, 32'h00000020);
        vecs[1]  = mk(1, 32'h00AB01FF,  0, 5'h00, 0, 8'h00, 0, 1, 0, 0, 0, 0, 6'h00, 32'h00000020);
        vecs[2]  = mk(0, 32'h0,         0, 5'h00, 0, 8'h00, 0, 0, 0, 0, 0, 0, 6'h00, 32'h00AB01FF);
        vecs[3]  = mk(1, 32'hFFFFFFFF,  0, 5'h00, 0, 8'h00, 0, 1, 0, 0, 0, 0, 6'h00, 32'h00AB01FF);
        vecs[4]  = mk(0, 32'h0,         0, 5'h00, 0, 8'h00, 0, 0, 0, 0, 0, 0, 6'h00, 32'h00FF01FF);
        vecs[5]  = mk(1, 32'h000C0001,  0, 5'h00, 0, 8'h00, 0, 1, 0, 0, 0, 0, 6'h00, 32'h00FF01FF);
        vecs[6]  = mk(1, 32'h0,         0, 5'h00, 0, 8'h08, 0, 0, 0, 0, 0, 0, 6'h00, 32'h000C0001);
        vecs[7]  = mk(0, 32'h0,         1, 5'h1F, 0, 8'h08, 0, 0, 0, 0, 1, 0, 6'h23, 32'h000C0001);
        vecs[8]  = mk(0, 32'h0,         0, 5'h00, 0, 8'h04, 0, 0, 0, 0, 1, 0, 6'h23, 32'h000C0001);
        vecs[9]  = mk(0, 32'h0,         0, 5'h00, 0, 8'h08, 1, 0, 0, 0, 1, 0, 6'h23, 32'h000C0001);
        vecs[10] = mk(0, 32'h0,         0, 5'h00, 1, 8'h08, 0, 0, 0, 0, 0, 1, 6'h23, 32'h000C0001);
        vecs[11] = mk(0, 32'h0,         0, 5'h00, 0, 8'h08, 0, 0, 0, 0, 0, 0, 6'h23, 32'h000C0020);
        vecs[12] = mk(0, 32'h0,         0, 5'h00, 1, 8'h08, 0, 0, 0, 1, 0, 0, 6'h23, 32'h000C0020);
        vecs[13] = mk(0, 32'h0,         0, 5'h00, 0, 8'h08, 0, 0, 0, 0, 0, 0, 6'h23, 32'h000C0001);
        vecs[14] = mk(0, 32'h0,         0, 5'h00, 0, 8'h08, 1, 0, 0, 0, 1, 0, 6'h23, 32'h000C0001);
        vecs[15] = mk(1, 32'h0,         1, 5'h05, 1, 8'h00, 0, 0, 0, 0, 0, 1, 6'h23, 32'h000C0001);
        vecs[16] = mk(1, 32'h0,         1, 5'h05, 1, 8'h00, 0, 0, 1, 0, 0, 0, 6'h23, 32'h000C0020);
        vecs[17] = mk(1, 32'h00000021,  0, 5'h00, 0, 8'h00, 0, 0, 0, 0, 1, 0, 6'h05, 32'h000C0020);
        vecs[18] = mk(1, 32'h00000021,  0, 5'h00, 0, 8'h00, 1, 0, 0, 0, 1, 0, 6'h05, 32'h000C0020);
        vecs[19] = mk(1, 32'h00000021,  0, 5'h00, 0, 8'h00, 1, 0, 0, 0, 0, 1, 6'h05, 32'h000C0020);
        vecs[20] = mk(1, 32'h00000021,  0, 5'h00, 0, 8'h00, 1, 1, 0, 0, 0, 0, 6'h05, 32'h000C0030);
        vecs[21] = mk(0, 32'h0,         0, 5'h00, 0, 8'h00, 1, 0, 0, 0, 0, 0, 6'h05, 32'h00000021);
        vecs[22] = mk(1, 32'h00F00001,  0, 5'h00, 0, 8'h00, 0, 1, 0, 0, 0, 0, 6'h05, 32'h00000021);
        vecs[23] = mk(0, 32'h0,         0, 5'h00, 1, 8'hA0, 0, 0, 0, 0, 0, 0, 6'h05, 32'h00F00001);
        vecs[24] = mk(0, 32'h0,         0, 5'h00, 0, 8'h00, 0, 0, 0, 0, 1, 0, 6'h25, 32'h00F00001);

        // Values held under reset.
        #12;
        check("rst bits",      st_bits,                  32'h00000020);
        check("rst cause",     {26'd0, trap_cause},      32'h0);
        check("rst drain_req", {31'd0, bus.io_drain_req}, 32'h0);
        check("rst trap_fire", {31'd0, trap_fire},        32'h0);
        #11;
        reset_n = 1'b1;
        next_cycle();

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            @(negedge clk);
            fields = {8'h00, st_im, st_zero, st_vm, st_s64, st_u64, st_s, st_ps,
                      st_ec, st_ev, st_ef, st_et};
            check($sformatf("r%0d csr_ready", i),  {31'd0, bus.io_csr_ready},  {31'd0, vecs[i].csr_ready});
            check($sformatf("r%0d exc_ready", i),  {31'd0, bus.io_exc_ready},  {31'd0, vecs[i].exc_ready});
            check($sformatf("r%0d eret_ready", i), {31'd0, bus.io_eret_ready}, {31'd0, vecs[i].eret_ready});
            check($sformatf("r%0d drain_req", i),  {31'd0, bus.io_drain_req},  {31'd0, vecs[i].drain_req});
            check($sformatf("r%0d trap_fire", i),  {31'd0, trap_fire},         {31'd0, vecs[i].trap_fire});
            check($sformatf("r%0d trap_cause", i), {26'd0, trap_cause},        {26'd0, vecs[i].cause});
            check($sformatf("r%0d bits", i),       st_bits,                    vecs[i].bits);
            check($sformatf("r%0d fields", i),     fields,                     vecs[i].bits);
            next_cycle();
        end

        // Last vector left the FSM in DRAIN: asynchronous reset mid-DRAIN.
        @(negedge clk);
        check("drain before rst", {31'd0, bus.io_drain_req}, 32'h1);
        #2;
        reset_n = 1'b0;
        bus.io_drain_done = 1'b1;
        #1;
        check("rstd drain_req", {31'd0, bus.io_drain_req}, 32'h0);
        check("rstd trap_fire", {31'd0, trap_fire},        32'h0);
        check("rstd bits",      st_bits,                   32'h00000020);
        check("rstd cause",     {26'd0, trap_cause},       32'h0);
        next_cycle();
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("post rstd fire c%0d", k),  {31'd0, trap_fire},        32'h0);
            check($sformatf("post rstd drain c%0d", k), {31'd0, bus.io_drain_req}, 32'h0);
            next_cycle();
        end

        // Reach TRAP via interrupt on line 0, then reset while trap_fire is high.
        drive(mk(1, 32'h00010001, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0));
        next_cycle();
        drive(mk(0, 32'h0, 0, 0, 0, 8'h01, 0, 0, 0, 0, 0, 0, 0, 0));
        next_cycle();
        bus.io_drain_done = 1'b1;
        @(negedge clk);
        check("trapseq drain_req", {31'd0, bus.io_drain_req}, 32'h1);
        check("trapseq cause",     {26'd0, trap_cause},       32'h20);
        next_cycle();
        bus.io_drain_done = 1'b0;
        ip = 8'h00;
        @(negedge clk);
        check("trapseq fire", {31'd0, trap_fire}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rstt trap_fire", {31'd0, trap_fire}, 32'h0);
        check("rstt bits",      st_bits,            32'h00000020);
        next_cycle();
        reset_n = 1'b1;
        @(negedge clk);
        check("post rstt fire", {31'd0, trap_fire}, 32'h0);
        check("post rstt bits", st_bits,            32'h00000020);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
